// File: rtl/sr_flop_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : sr_flop_bank_if
// Description : Bundle of the per-channel request inputs and status outputs
//               of sr_flop_bank. The master drives requests; the slave (the
//               flop bank) returns state, edge pulses and conflict status.
// Revision    : 1.0 - initial release
// ============================================================================
interface sr_flop_bank_if #(
  parameter int CHANNELS = 8
);
  logic [CHANNELS-1:0] in_en;
  logic [CHANNELS-1:0] in_s;
  logic [CHANNELS-1:0] in_r;
  logic                conf_clr;
  logic [CHANNELS-1:0] out_q;
  logic [CHANNELS-1:0] out_q_bar;
  logic [CHANNELS-1:0] out_rise;
  logic [CHANNELS-1:0] out_fall;
  logic [CHANNELS-1:0] out_conflict;
  logic                out_any;

  modport master (
    output in_en, in_s, in_r, conf_clr,
    input  out_q, out_q_bar, out_rise, out_fall, out_conflict, out_any
  );

  modport slave (
    input  in_en, in_s, in_r, conf_clr,
    output out_q, out_q_bar, out_rise, out_fall, out_conflict, out_any
  );
endinterface
`default_nettype wire

// File: rtl/sr_flop_bank.sv
`default_nettype none
// ============================================================================
// Module      : sr_flop_bank
// Description : Bank of CHANNELS edge-triggered SR state bits with per-channel
//               enable, selectable S=R=1 resolution (MODE), rise/fall event
//               pulses, sticky conflict status and a registered OR summary.
//               Optional macro SR_FLOP_BANK_SYNC_EN inserts a 2-flop
//               synchroniser on in_en/in_s/in_r (3-cycle input latency).
// Revision    : 1.0 - initial release
// ============================================================================
module sr_flop_bank #(
  parameter int CHANNELS = 8,
  parameter int MODE     = 0,
  parameter bit RESET_Q  = 1'b0
) (
  input logic           clk,
  input logic           reset,
  sr_flop_bank_if.slave bus
);

  logic [CHANNELS-1:0] w_en;
  logic [CHANNELS-1:0] w_s;
  logic [CHANNELS-1:0] w_r;
  logic [CHANNELS-1:0] w_next;
  logic [CHANNELS-1:0] w_conf_evt;

  logic [CHANNELS-1:0] r_q;
  logic [CHANNELS-1:0] r_rise;
  logic [CHANNELS-1:0] r_fall;
  logic [CHANNELS-1:0] r_conflict;
  logic                r_any;

`ifdef SR_FLOP_BANK_SYNC_EN
  logic [CHANNELS-1:0] r_en_meta;
  logic [CHANNELS-1:0] r_en_sync;
  logic [CHANNELS-1:0] r_s_meta;
  logic [CHANNELS-1:0] r_s_sync;
  logic [CHANNELS-1:0] r_r_meta;
  logic [CHANNELS-1:0] r_r_sync;

  // Two-stage synchronisers for the asynchronous request inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en_meta <= '0;
      r_en_sync <= '0;
      r_s_meta  <= '0;
      r_s_sync  <= '0;
      r_r_meta  <= '0;
      r_r_sync  <= '0;
    end else begin
      r_en_meta <= bus.in_en;
      r_en_sync <= r_en_meta;
      r_s_meta  <= bus.in_s;
      r_s_sync  <= r_s_meta;
      r_r_meta  <= bus.in_r;
      r_r_sync  <= r_r_meta;
    end
  end

  assign w_en = r_en_sync;
  assign w_s  = r_s_sync;
  assign w_r  = r_r_sync;
`else
  assign w_en = bus.in_en;
  assign w_s  = bus.in_s;
  assign w_r  = bus.in_r;
`endif

  // Resolution of a simultaneous set and reset request for one channel
  function automatic logic f_resolve(input logic q);
    case (MODE)
      0:       return 1'b1;
      1:       return 1'b0;
      3:       return ~q;
      default: return q;
    endcase
  endfunction

  // Next-state and conflict-event decode; a disabled channel never looks at
  // its S/R bits, so unknowns there cannot leak into state or status
  always_comb begin
    w_next     = r_q;
    w_conf_evt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_en[i]) begin
        case ({w_s[i], w_r[i]})
          2'b10: w_next[i] = 1'b1;
          2'b01: w_next[i] = 1'b0;
          2'b11: begin
            w_next[i]     = f_resolve(r_q[i]);
            w_conf_evt[i] = 1'b1;
          end
          default: w_next[i] = r_q[i];
        endcase
      end
    end
  end

  // Channel state, edge pulses, sticky conflict (set beats clear) and OR flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q        <= {CHANNELS{RESET_Q}};
      r_rise     <= '0;
      r_fall     <= '0;
      r_conflict <= '0;
      r_any      <= RESET_Q;
    end else begin
      r_q        <= w_next;
      r_rise     <= w_next & ~r_q;
      r_fall     <= ~w_next & r_q;
      r_conflict <= (r_conflict & ~{CHANNELS{bus.conf_clr}}) | w_conf_evt;
      r_any      <= |w_next;
    end
  end

  assign bus.out_q        = r_q;
  assign bus.out_q_bar    = ~r_q;
  assign bus.out_rise     = r_rise;
  assign bus.out_fall     = r_fall;
  assign bus.out_conflict = r_conflict;
  assign bus.out_any      = r_any;

endmodule
`default_nettype wire

// File: tb/tb_sr_flop_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_flop_bank
// Description : Directed bench for sr_flop_bank. Four instances (MODE 0..3,
//               RESET_Q=1, CHANNELS=8) share one stimulus stream; each step
//               checks state, inverse, pulses, conflict and OR flag against
//               hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_flop_bank;
  localparam int CH = 8;

  logic clk = 1'b0;
  logic reset;
  logic [CH-1:0] en, s, r;
  logic clr;

  logic [CH-1:0] q_a [4];
  logic [CH-1:0] qb_a[4];
  logic [CH-1:0] ri_a[4];
  logic [CH-1:0] fa_a[4];
  logic [CH-1:0] cf_a[4];
  logic          an_a[4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    sr_flop_bank_if #(.CHANNELS(CH)) bus ();
    assign bus.in_en    = en;
    assign bus.in_s     = s;
    assign bus.in_r     = r;
    assign bus.conf_clr = clr;
    sr_flop_bank #(.CHANNELS(CH), .MODE(m), .RESET_Q(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
    assign q_a[m]  = bus.out_q;
    assign qb_a[m] = bus.out_q_bar;
    assign ri_a[m] = bus.out_rise;
    assign fa_a[m] = bus.out_fall;
    assign cf_a[m] = bus.out_conflict;
    assign an_a[m] = bus.out_any;
  end

  task automatic chk(input string tag, input int m, input logic [CH-1:0] obs,
                     input logic [CH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s mode%0d observed=%h expected=%h", tag, m, obs, exp);
    end
  endtask

  // Full check of one instance: q, inverse, pulses, conflict, OR flag
  task automatic chk_mode(input string tag, input int m, input logic [CH-1:0] eq,
                          input logic [CH-1:0] er, input logic [CH-1:0] ef,
                          input logic [CH-1:0] ec);
    chk({tag, ".q"},    m, q_a[m],  eq);
    chk({tag, ".qbar"}, m, qb_a[m], ~eq);
    chk({tag, ".rise"}, m, ri_a[m], er);
    chk({tag, ".fall"}, m, fa_a[m], ef);
    chk({tag, ".conf"}, m, cf_a[m], ec);
    chk({tag, ".any"},  m, {7'd0, an_a[m]}, {7'd0, |eq});
  endtask

  task automatic chk_all(input string tag, input logic [CH-1:0] eq,
                         input logic [CH-1:0] er, input logic [CH-1:0] ef,
                         input logic [CH-1:0] ec);
    for (int m = 0; m < 4; m++) chk_mode(tag, m, eq, er, ef, ec);
  endtask

  task automatic drive(input logic [CH-1:0] e, input logic [CH-1:0] s_i,
                       input logic [CH-1:0] r_i, input logic c);
    en  = e;
    s   = s_i;
    r   = r_i;
    clr = c;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    cyc();
    cyc();
    chk_all("reset", 8'hFF, 8'h00, 8'h00, 8'h00);

    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      cyc();
      chk_all("idle", 8'hFF, 8'h00, 8'h00, 8'h00);
    end

    // Bring every channel to 0 so the set/clear sequence starts from q=0
    drive(8'hFF, 8'h00, 8'hFF, 1'b0);
    cyc();
    chk_all("clear_all", 8'h00, 8'h00, 8'hFF, 8'h00);
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    cyc();
    chk_all("quiet", 8'h00, 8'h00, 8'h00, 8'h00);

    drive(8'hFF, 8'h05, 8'h00, 1'b0);
    cyc();
    chk_all("set05", 8'h05, 8'h05, 8'h00, 8'h00);
    drive(8'hFF, 8'h00, 8'h01, 1'b0);
    cyc();
    chk_all("clr01", 8'h04, 8'h00, 8'h01, 8'h00);

    // S=R=1 on channel 0 for four cycles
    drive(8'h01, 8'h01, 8'h01, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk_mode("conf_m0", 0, 8'h05, (k == 0) ? 8'h01 : 8'h00, 8'h00, 8'h01);
      chk_mode("conf_m1", 1, 8'h04, 8'h00, 8'h00, 8'h01);
      chk_mode("conf_m2", 2, 8'h04, 8'h00, 8'h00, 8'h01);
      if (k % 2 == 0) chk_mode("conf_m3", 3, 8'h05, 8'h01, 8'h00, 8'h01);
      else            chk_mode("conf_m3", 3, 8'h04, 8'h00, 8'h01, 8'h01);
    end

    drive(8'h00, 8'h00, 8'h00, 1'b1);
    cyc();
    chk_mode("cclr", 0, 8'h05, 8'h00, 8'h00, 8'h00);
    for (int m = 1; m < 4; m++) chk_mode("cclr", m, 8'h04, 8'h00, 8'h00, 8'h00);

    // Disabled channels ignore S/R completely
    drive(8'h00, 8'hFF, 8'hFF, 1'b0);
    repeat (5) begin
      cyc();
      chk_mode("gate", 0, 8'h05, 8'h00, 8'h00, 8'h00);
      for (int m = 1; m < 4; m++) chk_mode("gate", m, 8'h04, 8'h00, 8'h00, 8'h00);
    end
    drive(8'h80, 8'h80, 8'h00, 1'b0);
    cyc();
    chk_mode("en80", 0, 8'h85, 8'h80, 8'h00, 8'h00);
    for (int m = 1; m < 4; m++) chk_mode("en80", m, 8'h84, 8'h80, 8'h00, 8'h00);

    // New conflict in the same cycle as conf_clr: set wins
    drive(8'h04, 8'h04, 8'h04, 1'b1);
    cyc();
    chk_mode("race", 0, 8'h85, 8'h00, 8'h00, 8'h04);
    chk_mode("race", 1, 8'h80, 8'h00, 8'h04, 8'h04);
    chk_mode("race", 2, 8'h84, 8'h00, 8'h00, 8'h04);
    chk_mode("race", 3, 8'h80, 8'h00, 8'h04, 8'h04);
    drive(8'h00, 8'h00, 8'h00, 1'b1);
    cyc();
    chk_mode("race_clr", 0, 8'h85, 8'h00, 8'h00, 8'h00);
    chk_mode("race_clr", 1, 8'h80, 8'h00, 8'h00, 8'h00);
    chk_mode("race_clr", 2, 8'h84, 8'h00, 8'h00, 8'h00);
    chk_mode("race_clr", 3, 8'h80, 8'h00, 8'h00, 8'h00);

    // Toggle in progress, then asynchronous reset between edges
    drive(8'h01, 8'h01, 8'h01, 1'b0);
    cyc();
    chk_mode("tog", 0, 8'h85, 8'h00, 8'h00, 8'h01);
    chk_mode("tog", 1, 8'h80, 8'h00, 8'h00, 8'h01);
    chk_mode("tog", 2, 8'h84, 8'h00, 8'h00, 8'h01);
    chk_mode("tog", 3, 8'h81, 8'h01, 8'h00, 8'h01);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_all("async_rst", 8'hFF, 8'h00, 8'h00, 8'h00);
    cyc();
    chk_all("rst_hold", 8'hFF, 8'h00, 8'h00, 8'h00);
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cyc();
    chk_all("rst_rel", 8'hFF, 8'h00, 8'h00, 8'h00);
    cyc();
    chk_all("rst_rel2", 8'hFF, 8'h00, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/sr_flop_bank.md
Name: sr_flop_bank

Overview:
- Parametrised, edge-triggered successor to the team's single-channel level-sensitive SR latch.
- Holds CHANNELS independent SR state bits, all clocked on clk rising edge.
- Conflict resolution (S and R both asserted) is selectable per instance.
- Adds per-channel enables, rise/fall event pulses and a sticky conflict status register.
- Sits between control/status sources (interrupt sources, sticky error flags) and software-visible status logic.

Parameters:
- CHANNELS, 8: number of independent SR channels (1..64).
- MODE, 0: conflict rule when in_s and in_r are both 1. 0 = set-dominant, 1 = reset-dominant, 2 = hold, 3 = toggle (JK behaviour).
- RESET_Q, 0: reset value of every out_q bit (0 or 1).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_en  input  CHANNELS  per-channel update enable; channel frozen when 0.
- in_s  input  CHANNELS  per-channel set request.
- in_r  input  CHANNELS  per-channel reset request.
- conf_clr  input  1  synchronous clear of the out_conflict sticky register.
- out_q  output  CHANNELS  registered channel state.
- out_q_bar  output  CHANNELS  always the bitwise inverse of out_q, including during reset.
- out_rise  output  CHANNELS  one-cycle pulse when the channel goes 0->1.
- out_fall  output  CHANNELS  one-cycle pulse when the channel goes 1->0.
- out_conflict  output  CHANNELS  sticky: channel saw S=R=1 with enable high.
- out_any  output  1  OR-reduction of out_q, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - out_q = {CHANNELS{RESET_Q}}; out_q_bar = inverse of out_q.
  - out_rise, out_fall, out_conflict = 0.
  - out_any = RESET_Q.
  - Deassertion takes effect at the next clk edge; no update is lost after release.
- Per channel i, each rising edge with in_en[i]=1:
  - S=1, R=0: q <= 1.
  - S=0, R=1: q <= 0.
  - S=0, R=0: hold.
  - S=1, R=1: apply MODE: set (0), clear (1), hold (2), invert (3).
- in_en[i]=0: q[i] holds regardless of S/R; no conflict is recorded.
- Latency: out_q updates one cycle after the inputs are sampled. out_any reflects the new out_q in the same cycle (computed from next-state, registered).
- out_rise[i] / out_fall[i]:
  - Registered alongside q; high for exactly the one cycle in which out_q[i] first shows the new value.
  - MODE 3 with S=R=1 held for consecutive cycles: q toggles every cycle, and rise and fall pulses alternate every cycle.
- out_conflict[i]: set when in_en[i]=1 and S=R=1, in every MODE.
- conf_clr: clears out_conflict on the next edge.
  - If conf_clr and a new conflict occur in the same cycle, set wins and the bit reads 1.
- Channels are fully independent; simultaneous activity on all channels is legal.
- Reset asserted mid-toggle or mid-pulse forces the reset values immediately. No pulse is emitted for the reset-induced change.
- X on in_s/in_r of a disabled channel must not propagate to any output.

Optional Feature:
- Macro: SR_FLOP_BANK_SYNC_EN.
- Defined:
  - in_s, in_r and in_en each pass through a 2-flop synchroniser per bit, reset to 0 by reset.
  - Input-to-out_q latency becomes 3 cycles.
  - conf_clr is not synchronised.
- Undefined: inputs are sampled directly; latency is 1 cycle.

Test Plan:
- Reset: CHANNELS=8, RESET_Q=1, hold reset low.
  - Required: out_q=8'hFF, out_q_bar=8'h00, out_rise/out_fall/out_conflict=0, out_any=1.
  - Release reset, idle 3 cycles: outputs unchanged.
- Basic set/clear: in_en=8'hFF, in_s=8'h05 for 1 cycle.
  - Required: out_q=8'h05 next cycle, out_rise=8'h05 for one cycle.
  - Then in_r=8'h01: out_q=8'h04, out_fall=8'h01.
- Conflict per MODE: drive S=R=1 on channel 0 for 4 cycles, starting from q=0.
  - MODE 0: q=1.
  - MODE 1: q=0.
  - MODE 2: q=0.
  - MODE 3: q sequence 1,0,1,0 with alternating rise/fall pulses.
  - All MODEs: out_conflict[0]=1 and stays 1.
- Enable gating: in_en=8'h00, in_s=8'hFF, in_r=8'hFF for 5 cycles.
  - Required: out_q unchanged, out_conflict=0.
  - Then in_en=8'h80 with in_s=8'h80: only out_q[7] sets.
- Sticky clear race: conflict on channel 2 asserted in the same cycle as conf_clr=1 -> out_conflict[2]=1. Next cycle conf_clr=1 with no conflict -> out_conflict[2]=0.
- Async reset mid-operation: MODE 3, toggling in progress.
  - Drop reset between clock edges: out_q goes to RESET_Q immediately, with no out_rise/out_fall pulse.
  - With SR_FLOP_BANK_SYNC_EN defined: after release, the first input change appears on out_q 3 cycles later.
